// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide with architectural HI/LO.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Signs are applied in a single FIX cycle. An operation takes WIDTH RUN
// cycles plus one FIX cycle.
//
//   state | meaning
//   IDLE  | waiting for start; mthi/mtlo writes accepted
//   RUN   | one multiply/divide iteration per cycle, counter counts down
//   FIX   | apply result signs / divide-by-zero result, update HI/LO
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q;
  logic [CNTW-1:0]      cnt_q;
  logic                 is_div_q;
  logic                 neg_res_q;   // quotient/product must be negated
  logic                 neg_rem_q;   // remainder takes dividend's sign
  logic                 bzero_q;
  logic [WIDTH-1:0]     a_raw_q;     // original dividend for divide-by-zero
  logic [WIDTH-1:0]     opnd_q;      // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0]   acc_q;       // product accumulator, multiplier in low half
  logic [WIDTH-1:0]     rem_q;       // partial remainder (always < divisor)
  logic [WIDTH-1:0]     quo_q;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q, dbz_q;

  logic                 op_signed;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand magnitudes, iteration datapath and sign fix-up
  always_comb begin
    op_signed = ~op[0];
    a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    div_diff  = {1'b0, rem_sh} - {2'b00, opnd_q};
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo_fix   = neg_res_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
  end

  // Sequencer, iteration registers and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      a_raw_q   <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_div_q  <= op[1];
            neg_res_q <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= op_signed & a[WIDTH-1];
            bzero_q   <= (b == '0);
            a_raw_q   <= a;
            cnt_q     <= CNTW'(WIDTH);
            rem_q     <= '0;
            if (op[1]) begin
              opnd_q <= b_mag;
              quo_q  <= a_mag;
              acc_q  <= '0;
            end else begin
              opnd_q <= a_mag;
              acc_q  <= {{WIDTH{1'b0}}, b_mag};
              quo_q  <= '0;
            end
            state_q <= RUN;
          end else begin
            if (wr_hi) hi_q <= wdata;
            if (wr_lo) lo_q <= wdata;
          end
        end
        RUN: begin
          if (is_div_q) begin
            if (!div_diff[WIDTH+1]) begin
              rem_q <= div_diff[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= rem_sh[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) state_q <= FIX;
        end
        FIX: begin
          if (!is_div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (bzero_q) begin
            hi_q  <= a_raw_q;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an
// arithmetic reference model (64-bit products, native / and %).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        wr_hi = 1'b0, wr_lo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_hi = '0, exp_lo = '0;

  muldiv_unit #(.WIDTH(32), .CNTW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS mult/multu/div/divu semantics in plain 64-bit arithmetic
  task automatic ref_op(input logic [1:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    rz = 1'b0;
    case (rop)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, ra} * {32'b0, rb};
      default: begin
        if (rb == 0) begin
          p  = {ra, 32'hFFFF_FFFF};
          rz = 1'b1;
        end else begin
          if (rop == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'({32'b0, ra}) / longint'({32'b0, rb});
            r = longint'({32'b0, ra}) % longint'({32'b0, rb});
          end
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    rh = p[63:32];
    rl = p[31:0];
  endtask

  // Issue one op (called at posedge+1 in IDLE), run it to the done cycle and check.
  // inj: busy cycle at which to pulse start+wr_hi (0 = none). drop_lo: assert wr_lo with start.
  task automatic run_op(input string tag, input logic [1:0] rop, input logic [31:0] ra,
                        input logic [31:0] rb, input int inj, input bit drop_lo);
    logic [31:0] eh, el;
    logic        ez;
    int          n;
    bit          hold_ok, done_ok;
    ref_op(rop, ra, rb, eh, el, ez);
    op = rop; a = ra; b = rb; start = 1'b1;
    wr_lo = drop_lo; wdata = 32'h5555_AAAA;
    step();
    start = 1'b0; wr_lo = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    n = 0; hold_ok = 1; done_ok = 1;
    while (busy === 1'b1 && n < 100) begin
      if (done !== 1'b0 || div_by_zero !== 1'b0) done_ok = 0;
      if (hi !== exp_hi || lo !== exp_lo) hold_ok = 0;
      n++;
      if (n == inj) begin
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
        wr_hi = 1'b1; wdata = 32'h1234;
      end else begin
        start = 1'b0; wr_hi = 1'b0;
      end
      step();
    end
    start = 1'b0; wr_hi = 1'b0;
    chk({tag, " busy_len"}, 64'(n), 64'd33);
    chk({tag, " quiet_while_busy"}, {63'b0, done_ok}, 64'd1);
    chk({tag, " hold_while_busy"}, {63'b0, hold_ok}, 64'd1);
    chk({tag, " done"}, {63'b0, done}, 64'd1);
    chk({tag, " hi"}, {32'b0, hi}, {32'b0, eh});
    chk({tag, " lo"}, {32'b0, lo}, {32'b0, el});
    chk({tag, " dbz"}, {63'b0, div_by_zero}, {63'b0, ez});
    exp_hi = eh;
    exp_lo = el;
  endtask

  initial begin
    int          k;
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    #12;
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset done", {63'b0, done}, 64'd0);
    chk("reset hi", {32'b0, hi}, 64'd0);
    chk("reset lo", {32'b0, lo}, 64'd0);
    reset = 1'b0;
    step();

    run_op("mult -3*7",      2'b00, 32'hFFFF_FFFD, 32'd7,         0, 0);
    run_op("multu max*max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    // back-to-back: issued in the done cycle
    run_op("mult -1*-1",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op("div -7/2",       2'b10, 32'hFFFF_FFF9, 32'd2,         0, 0);
    run_op("divu 7/2",       2'b11, 32'd7,         32'd2,         0, 0);
    run_op("div ovf",        2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("divu 100/0",     2'b11, 32'd100,       32'd0,         0, 0);
    step();
    chk("dbz one cycle", {63'b0, div_by_zero}, 64'd0);
    chk("done one cycle", {63'b0, done}, 64'd0);

    run_op("div -5/0",       2'b10, 32'hFFFF_FFFB, 32'd0,         0, 0);
    step();
    run_op("multu 5*6 inj",  2'b01, 32'd5,         32'd6,         5, 0);
    step();
    chk("inj no restart busy", {63'b0, busy}, 64'd0);
    chk("inj no restart hi", {32'b0, hi}, {32'b0, exp_hi});

    // asynchronous reset mid-operation
    op = 2'b00; a = 32'd1234; b = 32'd5678; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("pre-reset busy", {63'b0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", {63'b0, busy}, 64'd0);
    chk("async reset done", {63'b0, done}, 64'd0);
    chk("async reset hi", {32'b0, hi}, 64'd0);
    chk("async reset lo", {32'b0, lo}, 64'd0);
    exp_hi = '0; exp_lo = '0;
    #3 reset = 1'b0;
    step();

    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hABCD;
    step();
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mthi", {32'b0, hi}, 64'h0000_ABCD);
    chk("mtlo", {32'b0, lo}, 64'h0000_ABCD);
    exp_hi = 32'hABCD; exp_lo = 32'hABCD;
    wr_hi = 1'b1; wdata = 32'h0F0F_0F0F;
    step();
    wr_hi = 1'b0;
    chk("mthi only hi", {32'b0, hi}, 64'h0F0F_0F0F);
    chk("mthi only lo", {32'b0, lo}, 64'h0000_ABCD);
    exp_hi = 32'h0F0F_0F0F;
    run_op("mult 2*3 drop wr_lo", 2'b00, 32'd2, 32'd3, 0, 1);
    step();

    // random operations, with a bias toward boundary operands
    for (k = 0; k < 24; k++) begin
      rop = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", k, rop), rop, ra, rb, 0, 0);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
    chk("final done low", {63'b0, done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the single-cycle ALU in the MIPS datapath and replaces its combinational mult/div and HI/LO path.
- The datapath issues mult/multu/div/divu with start and stalls the PC while busy. mfhi/mflo read hi/lo directly; mthi/mtlo write through wr_hi/wr_lo.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNTW, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue an operation; sampled at posedge.
- op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- a  input  WIDTH  multiplicand or dividend (rs).
- b  input  WIDTH  multiplier or divisor (rt).
- wr_hi  input  1  mthi strobe.
- wr_lo  input  1  mtlo strobe.
- wdata  input  WIDTH  mthi/mtlo data.
- busy  output  1  operation in progress; the datapath must stall.
- done  output  1  one-cycle pulse when hi/lo have just been updated.
- div_by_zero  output  1  valid with done; high if a div/divu had b==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. Reset forces state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, and clears the counter and work registers. This applies at any time, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, FIX. busy = (state != IDLE). done and div_by_zero are registered.
- IDLE:
  - start=1 at posedge: latch op; latch |a| and |b| for signed ops (raw values for unsigned ops); record the result-sign bits; counter=WIDTH; go to RUN.
  - Otherwise wr_hi loads hi<=wdata and wr_lo loads lo<=wdata; both may fire in the same cycle.
  - start has priority: wr_hi/wr_lo in the same cycle as start are dropped.
- RUN: one iteration per cycle; counter decrements; go to FIX when the counter reaches 1→0 (exactly WIDTH RUN cycles).
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle, remainder WIDTH+1 bits.
- FIX (one cycle):
  - Multiply: if signed and the signs differ, negate the 2*WIDTH product. hi<=upper half, lo<=lower half.
  - Divide: negate the quotient if the signs differ; the remainder takes the dividend's sign. lo<=quotient, hi<=remainder.
  - Divide by zero (b==0 at start): lo<=all ones, hi<=a (original value), div_by_zero<=1.
  - Signed overflow (-2^(W-1) / -1): lo<=0x80000000, hi<=0. This falls out of the magnitude algorithm.
  - Next state IDLE; done<=1 for exactly the following cycle.
- Latency: start accepted at edge E0; busy=1 for cycles E0+1 through E0+WIDTH+1 (33 cycles). hi/lo and done are valid in the cycle after E0+WIDTH+1.
- done and div_by_zero are 0 in every cycle except the one after FIX.
- hi/lo hold their previous values throughout RUN and FIX until the FIX edge.
- start while busy: ignored, no effect. wr_hi/wr_lo while busy: ignored.
- start in the done cycle (state IDLE): accepted normally.
- Operands a and b need not be held after the accept edge.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=7 → after 33 busy cycles, done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_by_zero=0.
- multu a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Also check mult a=b=0xFFFFFFFF → hi=0, lo=1.
- div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1. div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- divu a=100, b=0 → lo=0xFFFFFFFF, hi=0x64, div_by_zero=1 for exactly the done cycle.
- During a multu 5*6: pulse start (op=divu, a=9, b=3) and wr_hi (wdata=0x1234) at cycle 5 → both ignored; final hi=0, lo=30; busy length still 33.
- Assert reset at busy cycle 10 of a mult → busy, done, hi, lo are 0 immediately (asynchronous). After release: wr_hi=1 and wr_lo=1 with wdata=0xABCD → hi=lo=0xABCD next cycle. Then start mult 2*3 with wr_lo=1 in the same cycle → wr_lo dropped; lo=6 at done.
